// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared multiplier definitions: state encoding, sizes, carry rebuild
//
// Purpose : types and helpers shared by the shift-add multiplier and any other
//           user of the shared 32-bit adder (which has no carry output).
// Contents: mul_state_e   FSM state encoding (IDLE, CALC, DONE, NEG_LO, NEG_HI)
//           MUL_WIDTH     operand width, fixed to the adder width
//           MUL_ITER      number of shift-add iterations
//           carry_rebuild recovers the adder carry-out from the operand and sum MSBs
package mul_pkg;

    typedef enum logic [2:0] {
        MUL_IDLE   = 3'd0,
        MUL_CALC   = 3'd1,
        MUL_DONE   = 3'd2,
        MUL_NEG_LO = 3'd3,
        MUL_NEG_HI = 3'd4
    } mul_state_e;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_ITER  = 32;

    // Carry out of the MSB: both operand MSBs set always carry; exactly one set
    // carries only if the sum MSB came out clear (the carry-in to the MSB was 1).
    function automatic logic carry_rebuild(
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb
    );
        return (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);
    endfunction

endpackage

// File: rtl/mul_seq_shift_add.sv
// rtl/mul_seq_shift_add.sv - iterative 32x32->64 shift-add multiplier on a shared external adder
//
// Purpose : retires one multiplier bit per cycle by driving the shared 32-bit
//           adder (add_src1/add_src2) and consuming its combinational sum.
//           Optional macro MUL_SIGNED_EN adds signed operation (op_signed port,
//           NEG_LO/NEG_HI states that negate the 64-bit result via the adder).
// Ports   : clk        rising-edge clock
//           rst        synchronous reset, active-high
//           in_valid   operand pair valid        in_ready  block can accept operands
//           op_a       multiplicand              op_b      multiplier
//           op_signed  (MUL_SIGNED_EN only) treat operands as two's complement
//           out_valid  product valid             out_ready consumer accepts product
//           product    64-bit result, held until out_ready
//           add_src1   adder operand 1           add_src2  adder operand 2
//           add_result adder sum, same-cycle combinational return
module mul_seq_shift_add
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int ITER  = MUL_ITER
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
`ifdef MUL_SIGNED_EN
    input  logic               op_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_src1,
    output logic [WIDTH-1:0]   add_src2,
    input  logic [WIDTH-1:0]   add_result
);

    localparam logic [2:0] S_IDLE   = MUL_IDLE;
    localparam logic [2:0] S_CALC   = MUL_CALC;
    localparam logic [2:0] S_DONE   = MUL_DONE;
`ifdef MUL_SIGNED_EN
    localparam logic [2:0] S_NEG_LO = MUL_NEG_LO;
    localparam logic [2:0] S_NEG_HI = MUL_NEG_HI;
`endif

    localparam int               CNT_W    = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    logic [2:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] cnt;
    logic             carry;

`ifdef MUL_SIGNED_EN
    logic             neg_flag;
    logic             neg_carry;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Signed operands are multiplied as magnitudes; the sign is applied at the end.
    always_comb begin
        mag_a = op_a;
        mag_b = op_b;
        if (op_signed && op_a[WIDTH-1]) begin
            mag_a = ~op_a + WIDTH'(1);
        end
        if (op_signed && op_b[WIDTH-1]) begin
            mag_b = ~op_b + WIDTH'(1);
        end
    end
`endif

    // Adder operands are forced to zero outside the working states so the
    // shared adder sees quiet inputs while the ALU or nobody is using it.
    always_comb begin
        add_src1 = '0;
        add_src2 = '0;
        case (state)
            S_CALC: begin
                add_src1 = acc_hi;
                add_src2 = acc_lo[0] ? mcand : '0;
            end
`ifdef MUL_SIGNED_EN
            S_NEG_LO: begin
                add_src1 = ~acc_lo;
                add_src2 = WIDTH'(1);
            end
            S_NEG_HI: begin
                add_src1 = ~acc_hi;
                add_src2 = WIDTH'(neg_carry);
            end
`endif
            default: begin
                add_src1 = '0;
                add_src2 = '0;
            end
        endcase
    end

    assign carry     = carry_rebuild(add_src1[WIDTH-1], add_src2[WIDTH-1], add_result[WIDTH-1]);
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign product   = (state == S_DONE) ? {acc_hi, acc_lo} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
`ifdef MUL_SIGNED_EN
            neg_flag  <= 1'b0;
            neg_carry <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef MUL_SIGNED_EN
                        mcand    <= mag_a;
                        acc_lo   <= mag_b;
                        neg_flag <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`else
                        mcand    <= op_a;
                        acc_lo   <= op_b;
`endif
                        acc_hi   <= '0;
                        cnt      <= '0;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Shift the 65-bit {carry, sum, acc_lo} right by one: the sum LSB
                    // becomes a finished product bit and the consumed multiplier bit drops out.
                    acc_hi <= {carry, add_result[WIDTH-1:1]};
                    acc_lo <= {add_result[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
`ifdef MUL_SIGNED_EN
                        state <= neg_flag ? S_NEG_LO : S_DONE;
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef MUL_SIGNED_EN
                S_NEG_LO: begin
                    acc_lo    <= add_result;
                    neg_carry <= carry;
                    state     <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    acc_hi <= add_result;
                    state  <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_shift_add.sv
// tb/tb_mul_seq_shift_add.sv - directed self-checking bench for mul_seq_shift_add
module tb_mul_seq_shift_add;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic [31:0] add_src1;
    logic [31:0] add_src2;
    logic [31:0] add_result;

    int          errors = 0;
    int          checks = 0;

    logic [63:0] p;
    logic [63:0] p_hold;
    int          lat;
    logic        nz;
    logic        bad;

    always #5 clk = ~clk;

    // Stand-in for the shared 32-bit adder.
    assign add_result = add_src1 + add_src2;

    mul_seq_shift_add dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
`ifdef MUL_SIGNED_EN
        .op_signed  (op_signed),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .add_src1   (add_src1),
        .add_src2   (add_src2),
        .add_result (add_result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Handshake one operand pair and wait for out_valid; lat counts cycles from the
    // handshake cycle to the first out_valid cycle. nz flags add_src2 != 0 while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] res, output int cycles, output logic nzero);
        int g;
        nzero     = 1'b0;
        op_a      = a;
        op_b      = b;
        op_signed = s;
        in_valid  = 1'b1;
        g         = 0;
        while (in_ready !== 1'b1 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles   = 1;
        while (out_valid !== 1'b1 && cycles < 100) begin
            if (in_ready === 1'b0 && add_src2 !== 32'd0) nzero = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        res = product;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_product",   product,        64'd0);
        check("reset_add_src1",  64'(add_src1),  64'd0);
        check("reset_add_src2",  64'(add_src2),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'd3, 32'd5, 1'b0, p, lat, nz);
        check("3x5_product", p, 64'h0000_0000_0000_000F);
        check("3x5_latency", 64'(lat), 64'd33);
        check("done_add_src1_quiet", 64'(add_src1), 64'd0);
        check("done_add_src2_quiet", 64'(add_src2), 64'd0);
        consume();
        check("after_consume_in_ready", 64'(in_ready), 64'd1);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat, nz);
        check("max_x_max_product", p, 64'hFFFF_FFFE_0000_0001);
        consume();

        run_op(32'h8000_0000, 32'd2, 1'b0, p, lat, nz);
        check("msb_x_2_product", p, 64'h0000_0001_0000_0000);
        consume();

        run_op(32'hFFFF_FFFF, 32'd2, 1'b0, p, lat, nz);
        check("max_x_2_product", p, 64'h0000_0001_FFFF_FFFE);
        consume();

        run_op(32'h1234_5678, 32'd0, 1'b0, p, lat, nz);
        check("a_x_0_product", p, 64'd0);
        check("a_x_0_src2_zero", 64'(nz), 64'd0);
        consume();

        run_op(32'd0, 32'h9ABC_DEF0, 1'b0, p, lat, nz);
        check("0_x_b_product", p, 64'd0);
        check("0_x_b_src2_zero", 64'(nz), 64'd0);
        check("0_x_b_latency", 64'(lat), 64'd33);
        consume();

        // Stall in DONE with a new operand pair offered; it must be ignored.
        run_op(32'h0000_1234, 32'h0000_0010, 1'b0, p_hold, lat, nz);
        check("hold_product", p_hold, 64'h0000_0000_0001_2340);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            op_a     = 32'd100;
            op_b     = 32'd100;
            in_valid = (i >= 3 && i <= 5);
            @(posedge clk); #1;
            if (product !== p_hold || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        in_valid = 1'b0;
        check("hold_stable", 64'(bad), 64'd0);
        consume();
        check("hold_release_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("hold_no_capture", 64'(out_valid), 64'd0);
        run_op(32'd9, 32'd9, 1'b0, p, lat, nz);
        check("after_hold_product", p, 64'd81);
        check("after_hold_latency", 64'(lat), 64'd33);
        consume();

        // Abort in the middle of CALC.
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (16) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_add_src1",  64'(add_src1),  64'd0);
        check("abort_add_src2",  64'(add_src2),  64'd0);
        run_op(32'd7, 32'd6, 1'b0, p, lat, nz);
        check("after_abort_product", p, 64'd42);
        consume();

`ifdef MUL_SIGNED_EN
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, p, lat, nz);
        check("neg3_x_5_product", p, 64'hFFFF_FFFF_FFFF_FFF1);
        check("neg3_x_5_latency", 64'(lat), 64'd35);
        consume();
        run_op(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, p, lat, nz);
        check("neg3_x_neg5_product", p, 64'd15);
        check("neg3_x_neg5_latency", 64'(lat), 64'd33);
        consume();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_seq_shift_add.md
Name: mul_seq_shift_add

Overview:
- Iterative 32x32 -> 64-bit shift-add multiplier for the CPU datapath; it sits directly upstream of the shared 32-bit CLA adder (Adder_32bit).
- Each cycle it drives the adder's two source operands and consumes its 32-bit sum, retiring one multiplier bit per cycle.
- Connects to the core through valid/ready handshakes on operand input and product output.

Parameters:
- WIDTH, 32, operand width; fixed to the adder width, other values unsupported.
- ITER, 32, number of CALC iterations; must equal WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- op_a  in  32  multiplicand.
- op_b  in  32  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  64  op_a * op_b.
- add_src1  out  32  adder operand 1.
- add_src2  out  32  adder operand 2.
- add_result  in  32  adder sum; combinational return, same cycle.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. No other clock or reset.
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, internal registers (mcand, acc_hi, acc_lo, cnt) all 0, add_src1=0, add_src2=0.
- Reset mid-operation (any state) aborts; no output is produced for the aborted operation.
- States: IDLE, CALC, DONE (plus NEG_LO, NEG_HI with the optional feature).
- IDLE:
  - in_ready=1.
  - On in_valid: mcand<=op_a, acc_hi<=0, acc_lo<=op_b, cnt<=0, go CALC.
- CALC:
  - in_ready=0.
  - add_src1=acc_hi; add_src2 = acc_lo[0] ? mcand : 0.
  - Carry is rebuilt because the adder has no carry out: c = (add_src1[31]&add_src2[31]) | ((add_src1[31]|add_src2[31]) & ~add_result[31]).
  - Update: acc_hi<={c, add_result[31:1]}; acc_lo<={add_result[0], acc_lo[31:1]}; cnt<=cnt+1.
  - When cnt==ITER-1, go DONE after this update.
- DONE:
  - out_valid=1, product={acc_hi, acc_lo}, held stable until out_ready.
  - On out_valid & out_ready, go IDLE.
  - in_ready=0 in DONE, so there is no accept/complete overlap. Back-to-back throughput is one operation per 34 cycles when out_ready is held at 1.
- Latency: input handshake at cycle N -> out_valid asserted at cycle N+33.
- add_src1/add_src2 = 0 outside CALC, so the shared adder sees quiet inputs.
- Boundaries:
  - op_b=0: all iterations add 0, product=0.
  - 0xFFFFFFFF*0xFFFFFFFF: carry rebuild must give 0xFFFFFFFE_00000001.
  - in_valid in CALC/DONE is ignored; upstream must hold it until in_ready.

Optional Feature:
- Macro MUL_SIGNED_EN.
- Defined:
  - Adds input port op_signed (1 bit), sampled at the input handshake.
  - When op_signed=1, operands are captured as magnitudes (two's-complement negate if MSB set) and neg_flag = op_a[31]^op_b[31].
  - After CALC, if neg_flag the FSM goes NEG_LO then NEG_HI, using the adder to form the 64-bit two's complement.
  - NEG_LO: add_src1=~acc_lo, add_src2=1; the rebuilt carry is stored.
  - NEG_HI: add_src1=~acc_hi, add_src2=stored carry.
  - Then DONE. Latency 35 cycles when negated, 33 otherwise.
- Undefined: port op_signed absent; unsigned only; NEG states not generated.

Decomposition:
- Shared package mul_pkg: state enum (IDLE, CALC, DONE, NEG_LO, NEG_HI), localparams MUL_WIDTH=32 and MUL_ITER=32, and the carry-rebuild function (both this block and future ALU users need it).
- No sub-module inside this block. The adder stays an external instance so the ALU and the multiplier can share it.

Test Plan:
- Stimulus: op_a=3, op_b=5, out_ready=1. Required: product=0x0000000000000F; out_valid exactly 33 cycles after the input handshake.
- Stimulus: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF. Required: product=0xFFFFFFFE00000001 (checks carry rebuild).
- Stimulus: op_a=0x12345678, op_b=0; then op_a=0, op_b=0x9ABCDEF0. Required: both products=0; add_src2=0 on every CALC cycle.
- Stimulus: hold out_ready=0 for 10 cycles in DONE and pulse in_valid with new operands. Required: product and out_valid stable, in_ready=0, new operands not captured; after out_ready the next operation starts from IDLE.
- Stimulus: assert rst at CALC cycle 17. Required: next cycle state IDLE, in_ready=1, out_valid=0, add_src1/add_src2=0; a fresh op_a=7, op_b=6 then yields 42.
- MUL_SIGNED_EN only. Stimulus: op_signed=1, op_a=-3 (0xFFFFFFFD), op_b=5. Required: product=0xFFFFFFFFFFFFFFF1 at 35 cycles. Stimulus: op_a=-3, op_b=-5. Required: product=15 at 33 cycles.
